// File: rtl/tomasula_types.sv
// Shared type and default-size package for the Tomasulo back end.
// Holds the default machine sizes and the common data bus (CDB) bundle.
// Blocks that drive or snoop the CDB import this package.
package tomasula_types;

    localparam int NUM_FU_DEF    = 4;
    localparam int ROB_DEPTH_DEF = 8;
    localparam int XLEN_DEF      = 32;
    localparam int TAG_W_DEF     = $clog2(ROB_DEPTH_DEF);

    // One CDB broadcast: completion of ROB entry rob_tag with result value.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] rob_tag;
        logic [XLEN_DEF-1:0]  value;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - highest-priority requester index this cycle
//   gnt    - one-hot grant (all zero when no request)
//   winner - index of the granted requester (0 when none)
//   any    - a grant was issued
// Purely combinational; the priority pointer is owned by the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Scan ptr, ptr+1, ... (mod N); the first requester found wins.
    // The sum carries one extra bit so the wrap can be done by a single
    // conditional subtract instead of a divider.
    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished functional unit per cycle
// (round-robin), registers its tag/value onto the CDB and raises the
// matching ROB completion strobe.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   fu_req          - FU holds a result awaiting broadcast
//   fu_rob_tag      - ROB index of each FU's result
//   fu_value        - each FU's result value
//   flush           - mispredict flush; suppresses this cycle's grant
//   fu_gnt          - combinational one-hot grant back to the FUs
//   cdb_valid       - registered broadcast valid
//   cdb_rob_tag     - registered broadcast tag (holds when idle)
//   cdb_value       - registered broadcast value (holds when idle)
//   set_rob_valid   - one-hot ROB completion strobes decoded from the CDB
// The CDB register uses the package bundle, so ROB_DEPTH and XLEN are
// expected to match the package defaults.
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_FU    = NUM_FU_DEF,
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int XLEN      = XLEN_DEF,
    localparam int TAG_W    = $clog2(ROB_DEPTH),
    localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_req,
    input  logic [NUM_FU-1:0][TAG_W-1:0] fu_rob_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]  fu_value,
    input  logic                         flush,
    output logic [NUM_FU-1:0]            fu_gnt,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_rob_tag,
    output logic [XLEN-1:0]              cdb_value,
    output logic [ROB_DEPTH-1:0]         set_rob_valid
);

    logic [PTR_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] raw_gnt;
    logic [PTR_W-1:0]  winner;
    logic              raw_any;
    logic              grant_en;
    logic              granted;
    cdb_t              cdb_q;

    rr_arbiter #(
        .N     (NUM_FU),
        .PTR_W (PTR_W)
    ) u_rr (
        .req    (fu_req),
        .ptr    (rr_ptr),
        .gnt    (raw_gnt),
        .winner (winner),
        .any    (raw_any)
    );

    // Reset and flush both kill the grant in the same cycle, so a dropped
    // winner never reaches the CDB register and the pointer does not move.
    assign grant_en = !rst && !flush;
    assign granted  = grant_en && raw_any;
    assign fu_gnt   = grant_en ? raw_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            cdb_q  <= '0;
        end else begin
            cdb_q.valid <= granted;
            if (granted) begin
                cdb_q.rob_tag <= fu_rob_tag[winner];
                cdb_q.value   <= fu_value[winner];
                rr_ptr        <= (winner == PTR_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    assign cdb_valid   = cdb_q.valid;
    assign cdb_rob_tag = cdb_q.rob_tag;
    assign cdb_value   = cdb_q.value;

    // Tag decoder: one completion strobe per ROB entry.
    for (genvar k = 0; k < ROB_DEPTH; k++) begin : g_dec
        assign set_rob_valid[k] = cdb_q.valid && (cdb_q.rob_tag == TAG_W'(k));
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requesters.
REQ-002 Parameter ROB_DEPTH, default 8: ROB entries; tag width TAG_W = log2(ROB_DEPTH) = 3.
REQ-003 Parameter XLEN, default 32: result data width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fu_req[NUM_FU]  input  1 each  FU holds a completed result awaiting broadcast.
REQ-007 fu_rob_tag[NUM_FU]  input  TAG_W each  ROB index of that FU's result.
REQ-008 fu_value[NUM_FU]  input  XLEN each  result value.
REQ-009 flush  input  1  branch-mispredict flush from ROB control.
REQ-010 fu_gnt[NUM_FU]  output  1 each  combinational one-hot grant; FU drops or replaces request the next cycle.
REQ-011 cdb_valid  output  1  registered CDB broadcast valid.
REQ-012 cdb_rob_tag  output  TAG_W  registered broadcast tag.
REQ-013 cdb_value  output  XLEN  registered broadcast value.
REQ-014 set_rob_valid[ROB_DEPTH]  output  1 each  one-hot ROB-entry completion strobes to the ROB.

Function
REQ-015 At most one fu_gnt bit SHALL be high per cycle.
REQ-016 Grant SHALL be round-robin: winner = first i with fu_req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_FU.
REQ-017 On a grant, rr_ptr SHALL update to (winner+1) mod NUM_FU at the next edge; with no request, rr_ptr SHALL hold.
REQ-018 Latency: grant in cycle N SHALL yield cdb_valid=1, cdb_rob_tag=fu_rob_tag[winner], cdb_value=fu_value[winner] in cycle N+1.
REQ-019 A cycle without a grant SHALL yield cdb_valid=0 in the next cycle; cdb_rob_tag and cdb_value SHALL hold their previous values.
REQ-020 set_rob_valid[k] SHALL equal cdb_valid AND (cdb_rob_tag==k); all bits SHALL be 0 when cdb_valid=0.
REQ-021 Throughput: back-to-back grants every cycle SHALL be supported, one broadcast per cycle, with no bubble.
REQ-022 Fairness: a continuously asserted request SHALL be granted within NUM_FU cycles.
REQ-023 flush=1 in cycle N SHALL force all fu_gnt=0 in cycle N and cdb_valid=0 in cycle N+1, dropping any winner; rr_ptr SHALL hold.
REQ-024 A broadcast already registered (cdb_valid=1) in the flush cycle SHALL still be driven for that cycle; only younger grants are suppressed.
REQ-025 The block SHALL NOT check tag legality or duplicates; tags are forwarded unchanged.
REQ-026 rr_ptr wrap from NUM_FU-1 to 0 SHALL be modulo, with no extra cycle.

Reset
REQ-027 While rst=1, all fu_gnt SHALL be 0 regardless of fu_req.
REQ-028 At the first edge with rst=1, rr_ptr SHALL become 0, cdb_valid 0, cdb_rob_tag 0, cdb_value 0, and all set_rob_valid 0.
REQ-029 A rst asserted mid-burst SHALL discard the pending winner; no broadcast SHALL follow in the next cycle.

Structure
REQ-030 NUM_FU, ROB_DEPTH, XLEN defaults and the CDB bundle struct (valid, rob_tag, value) SHALL live in the shared tomasula_types package.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and rr_ptr; outputs one-hot gnt and winner index); broadcast registers and the tag decoder stay in cdb_arbiter.

Verification
REQ-032 Reset, then fu_req=4'b0000 for 5 cycles -> fu_gnt=0, cdb_valid=0, set_rob_valid=0 throughout.
REQ-033 fu_req=4'b1111 held 8 cycles, rr_ptr=0 -> grant order FU0,1,2,3,0,1,2,3; each cdb_rob_tag appears one cycle after its grant.
REQ-034 Single request FU2, tag 5, value 32'hDEADBEEF -> fu_gnt=4'b0100 in cycle N; cycle N+1 cdb_valid=1, tag=5, value=DEADBEEF, set_rob_valid=8'b0010_0000.
REQ-035 FU1 and FU3 requesting with rr_ptr=2 -> FU3 granted first, rr_ptr=0, then FU1 granted next cycle.
REQ-036 fu_req=4'b0011 with flush pulsed in cycle N -> fu_gnt=0 in N, cdb_valid=0 in N+1, FU0 granted in N+1 (rr_ptr unchanged).
REQ-037 rst asserted in a cycle with fu_req=4'b1000 -> no grant, cdb_valid=0 next cycle, rr_ptr=0 afterwards.
